gcd_requester: RTL and testbench
================================

# gcd_requester

Upstream sequencer for the GCD engine. Accepts operand pairs from a producer over a valid/ready handshake and issues each pair to the engine as a request. It waits for the engine's response, sanity-checks it, and returns the result, tagged with its original operands, to a consumer over a second valid/ready handshake. Operand pairs containing a zero are resolved locally and never reach the engine.

## Interface
- DATA_WIDTH, 8, width of operands and result
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before error; only used with GCD_REQ_TIMEOUT_EN
- clk_i  input  1  clock; all state updates on the rising edge
- nreset_i  input  1  reset, synchronous, active-low
- op_valid_i / op_ready_o  input / output  1 / 1  producer handshake
- op_a_i, op_b_i  input  DATA_WIDTH  operands, unsigned
- eng_req_valid_o / eng_req_ready_i  output / input  1 / 1  engine request handshake
- eng_a_o, eng_b_o  output  DATA_WIDTH  operands to engine
- eng_rsp_valid_i  input  1  single-cycle response strobe from engine
- eng_rsp_gcd_i  input  DATA_WIDTH  engine result
- res_valid_o / res_ready_i  output / input  1 / 1  consumer handshake
- res_gcd_o, res_a_o, res_b_o  output  DATA_WIDTH  result and its operands
- res_err_o  output  1  result invalid (bad response or timeout)
- busy_o  output  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset enters IDLE.
- IDLE:
  - op_ready_o=1.
  - On op_valid_i&&op_ready_o, latch a, b.
  - If a==0 or b==0: load res_gcd = a|b (gcd(0,0)=0) with err=0, and go to DONE.
  - Otherwise go to ISSUE.
- ISSUE:
  - eng_req_valid_o=1, with eng_a_o/eng_b_o driving the latched operands.
  - Hold valid and data stable until eng_req_ready_i, then go to WAIT.
- WAIT:
  - On eng_rsp_valid_i, latch eng_rsp_gcd_i.
  - err=1 if gcd==0 or gcd>min(a,b); else err=0.
  - Go to DONE.
- DONE:
  - res_valid_o=1. Hold res_gcd/res_a/res_b/res_err stable until res_ready_i, then go to IDLE.
- eng_rsp_valid_i outside WAIT is ignored, including the cycle of the request handshake.
- Comparisons are unsigned, at DATA_WIDTH. No arithmetic wider than DATA_WIDTH.
- One transaction in flight; op_ready_o is low outside IDLE.

## Timing
- Reset values:
  - All outputs 0, except op_ready_o=1 once the state is IDLE.
  - Result and operand registers are cleared to 0.
- All outputs are decoded from registered state and data; there is no combinational path from any input to any output.
- Minimum non-zero transaction, with the accept at cycle 0:
  - Cycle 1: request valid. If ready at cycle 1, WAIT from cycle 2.
  - If the response arrives at cycle 2, res_valid_o at cycle 3.
  - If res_ready_i at cycle 3, IDLE and next accept at cycle 4.
- Zero-operand transaction: res_valid_o in the cycle after accept.
- Reset mid-operation discards the transaction. A late engine response after reset lands in IDLE and is ignored.
- Response and timeout in the same cycle: the response wins.

## Configuration
- GCD_REQ_TIMEOUT_EN defined:
  - A cycle counter is cleared on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without a response, go to DONE with res_gcd_o=0 and res_err_o=1.
- GCD_REQ_TIMEOUT_EN undefined:
  - No counter is built and WAIT waits indefinitely.
  - res_err_o reflects only the response check.

## Structure
- Shared package gcd_pkg holds:
  - The state enum (IDLE/ISSUE/WAIT/DONE, 2-bit encoding).
  - The gcd_data operand-pair struct shared with the engine.
  - The default TIMEOUT_CYCLES constant.
- Optional sub-module gcd_rsp_check: combinational response validation (zero / greater-than-min check), reusable by the engine's bench scoreboard.
- FSM, operand/result registers and timeout counter live in gcd_requester.

## Test plan
- Nominal: a=12, b=18; engine ready immediately; response 6 one cycle into WAIT -> res_gcd_o=6, res_a_o=12, res_b_o=18, res_err_o=0, res_valid_o 3 cycles after accept.
- Zero bypass: a=0, b=9 -> eng_req_valid_o never rises; res_gcd_o=9, err=0 one cycle after accept. Also a=0, b=0 -> res_gcd_o=0.
- Backpressure, engine side: eng_req_ready_i low for 5 cycles with a=35, b=21 -> eng_req_valid_o held high and eng_a_o/eng_b_o stable at 35/21 for all 5 cycles.
- Backpressure, consumer side: res_ready_i low for 3 cycles -> outputs stable, op_ready_o=0 and new op_valid_i ignored throughout.
- Bad response: a=12, b=18 with response 0, then a second transaction with response 20 -> res_err_o=1 both times.
- Timeout with the macro and TIMEOUT_CYCLES=4: no response -> DONE with err=1, res_gcd_o=0 after 4 WAIT cycles. Without the macro the block stays in WAIT for 100 cycles.
- Reset asserted in WAIT, then eng_rsp_valid_i pulsed in IDLE -> all outputs 0, response ignored; next pair 8/12 returns 4 with no error.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester and engine: FSM states, operand pair, defaults.
package gcd_pkg;

  localparam int unsigned GcdDataWidth     = 8;
  localparam int unsigned GcdTimeoutCycles = 255;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } gcd_state_e;

  typedef struct packed {
    logic [GcdDataWidth-1:0] a;
    logic [GcdDataWidth-1:0] b;
  } gcd_data_t;

endpackage

// File: rtl/gcd_rsp_check.sv
// Combinational sanity check of an engine result: flags zero or a value above min(a, b).
module gcd_rsp_check #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] gcd,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] min_ab;

  always_comb begin
    min_ab = (a < b) ? a : b;
    err    = (gcd == '0) || (gcd > min_ab);
  end

endmodule

// File: rtl/gcd_requester.sv
// Sequencer issuing operand pairs to the GCD engine and returning checked results.
// Optional WAIT timeout enabled by defining GCD_REQ_TIMEOUT_EN.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = GcdDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = GcdTimeoutCycles
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic                  eng_req_valid_o,
  input  logic                  eng_req_ready_i,
  output logic [DATA_WIDTH-1:0] eng_a_o,
  output logic [DATA_WIDTH-1:0] eng_b_o,
  input  logic                  eng_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] eng_rsp_gcd_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_gcd_o,
  output logic [DATA_WIDTH-1:0] res_a_o,
  output logic [DATA_WIDTH-1:0] res_b_o,
  output logic                  res_err_o,
  output logic                  busy_o
);

  gcd_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic                  err_q, err_d;
  logic                  rsp_err;

  gcd_rsp_check #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_check (
    .a  (a_q),
    .b  (b_q),
    .gcd(eng_rsp_gcd_i),
    .err(rsp_err)
  );

`ifdef GCD_REQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;

  // Counter idles at zero outside WAIT, so it is cleared on every WAIT entry.
  assign cnt_d   = (state_q == StWait) ? cnt_q + 1'b1 : '0;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!nreset_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid_i) begin
          a_d   = op_a_i;
          b_d   = op_b_i;
          err_d = 1'b0;
          // gcd(x, 0) = x, gcd(0, 0) = 0: resolved without the engine.
          if (op_a_i == '0 || op_b_i == '0) begin
            gcd_d   = op_a_i | op_b_i;
            state_d = StDone;
          end else begin
            gcd_d   = '0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (eng_req_ready_i) state_d = StWait;
      end
      StWait: begin
        if (eng_rsp_valid_i) begin
          gcd_d   = eng_rsp_gcd_i;
          err_d   = rsp_err;
          state_d = StDone;
        end
`ifdef GCD_REQ_TIMEOUT_EN
        else if (timeout) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_ready_o      = (state_q == StIdle);
    eng_req_valid_o = (state_q == StIssue);
    res_valid_o     = (state_q == StDone);
    busy_o          = (state_q != StIdle);
    eng_a_o         = a_q;
    eng_b_o         = b_q;
    res_a_o         = a_q;
    res_b_o         = b_q;
    res_gcd_o       = gcd_q;
    res_err_o       = err_q;
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed table-driven bench for gcd_requester plus hand sequences for latency, reset, timeout.
module tb_gcd_requester;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         nreset;
  logic         op_valid, op_ready;
  logic [W-1:0] op_a, op_b;
  logic         eng_req_valid, eng_req_ready;
  logic [W-1:0] eng_a, eng_b;
  logic         eng_rsp_valid;
  logic [W-1:0] eng_rsp_gcd;
  logic         res_valid, res_ready;
  logic [W-1:0] res_gcd, res_a, res_b;
  logic         res_err, busy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  gcd_requester #(
    .DATA_WIDTH    (W),
`ifdef GCD_REQ_TIMEOUT_EN
    .TIMEOUT_CYCLES(4)
`else
    .TIMEOUT_CYCLES(255)
`endif
  ) dut (
    .clk_i          (clk),
    .nreset_i       (nreset),
    .op_valid_i     (op_valid),
    .op_ready_o     (op_ready),
    .op_a_i         (op_a),
    .op_b_i         (op_b),
    .eng_req_valid_o(eng_req_valid),
    .eng_req_ready_i(eng_req_ready),
    .eng_a_o        (eng_a),
    .eng_b_o        (eng_b),
    .eng_rsp_valid_i(eng_rsp_valid),
    .eng_rsp_gcd_i  (eng_rsp_gcd),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_gcd_o      (res_gcd),
    .res_a_o        (res_a),
    .res_b_o        (res_b),
    .res_err_o      (res_err),
    .busy_o         (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] rsp;
    int           eng_stall;
    int           res_stall;
    logic         bypass;
    logic [W-1:0] exp_gcd;
    logic         exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, " op_ready"}, 32'(op_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " eng_req_valid"}, 32'(eng_req_valid), 32'd0);
    chk({tag, " eng_ab"}, {16'd0, eng_a, eng_b}, 32'd0);
    chk({tag, " res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, " res_gcd_a_b"}, {8'd0, res_gcd, res_a, res_b}, 32'd0);
    chk({tag, " res_err"}, 32'(res_err), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    chk({t, " op_ready idle"}, 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b1; op_a = v.a; op_b = v.b;
    tick();
    op_valid = 1'b0; op_a = 8'hEE; op_b = 8'hEE;
    if (!v.bypass) begin
      for (int i = 0; i < v.eng_stall; i++) begin
        @(negedge clk);
        chk({t, " req_valid stall"}, 32'(eng_req_valid), 32'd1);
        chk({t, " req_ab stall"}, {16'd0, eng_a, eng_b}, {16'd0, v.a, v.b});
        tick();
      end
      // Spurious response during the handshake cycle must be ignored.
      eng_req_ready = 1'b1; eng_rsp_valid = 1'b1; eng_rsp_gcd = 8'hAA;
      @(negedge clk);
      chk({t, " req_valid"}, 32'(eng_req_valid), 32'd1);
      chk({t, " req_ab"}, {16'd0, eng_a, eng_b}, {16'd0, v.a, v.b});
      tick();
      eng_req_ready = 1'b0; eng_rsp_gcd = v.rsp;
      tick();
      eng_rsp_valid = 1'b0; eng_rsp_gcd = '0;
    end else begin
      @(negedge clk);
      chk({t, " no req on bypass"}, 32'(eng_req_valid), 32'd0);
    end
    for (int i = 0; i <= v.res_stall; i++) begin
      @(negedge clk);
      chk({t, " res_valid"}, 32'(res_valid), 32'd1);
      chk({t, " res_gcd"}, 32'(res_gcd), 32'(v.exp_gcd));
      chk({t, " res_a_b"}, {16'd0, res_a, res_b}, {16'd0, v.a, v.b});
      chk({t, " res_err"}, 32'(res_err), 32'(v.exp_err));
      chk({t, " op_ready busy"}, {30'd0, op_ready, busy}, 32'd1);
      if (i < v.res_stall) begin
        tick();
        op_valid = 1'b1; op_a = 8'd3; op_b = 8'd5;
      end
    end
    tick();
    op_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk({t, " back to idle"}, {30'd0, op_ready, res_valid}, 32'd2);
  endtask

  initial begin
    vecs[0]  = '{8'd12,  8'd18,  8'd6,   0, 0, 1'b0, 8'd6,   1'b0};
    vecs[1]  = '{8'd0,   8'd9,   8'd0,   0, 0, 1'b1, 8'd9,   1'b0};
    vecs[2]  = '{8'd0,   8'd0,   8'd0,   0, 0, 1'b1, 8'd0,   1'b0};
    vecs[3]  = '{8'd35,  8'd21,  8'd7,   5, 0, 1'b0, 8'd7,   1'b0};
    vecs[4]  = '{8'd12,  8'd18,  8'd0,   0, 0, 1'b0, 8'd0,   1'b1};
    vecs[5]  = '{8'd12,  8'd18,  8'd20,  0, 0, 1'b0, 8'd20,  1'b1};
    vecs[6]  = '{8'd7,   8'd0,   8'd0,   0, 2, 1'b1, 8'd7,   1'b0};
    vecs[7]  = '{8'd15,  8'd25,  8'd5,   1, 3, 1'b0, 8'd5,   1'b0};
    vecs[8]  = '{8'd255, 8'd255, 8'd255, 0, 0, 1'b0, 8'd255, 1'b0};
    vecs[9]  = '{8'd9,   8'd6,   8'd7,   0, 0, 1'b0, 8'd7,   1'b1};
    vecs[10] = '{8'd255, 8'd1,   8'd1,   0, 0, 1'b0, 8'd1,   1'b0};

    nreset = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
    eng_req_ready = 1'b0; eng_rsp_valid = 1'b0; eng_rsp_gcd = '0; res_ready = 1'b0;
    repeat (3) tick();
    nreset = 1'b1;
    chk_reset_outputs("reset");

    // Minimum latency: accept at cycle 0, response in cycle 2, result in cycle 3.
    tick();
    op_valid = 1'b1; op_a = 8'd12; op_b = 8'd18; eng_req_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    chk("lat c1 req_valid", 32'(eng_req_valid), 32'd1);
    tick();
    eng_req_ready = 1'b0; eng_rsp_valid = 1'b1; eng_rsp_gcd = 8'd6;
    @(negedge clk);
    chk("lat c2 wait", {30'd0, busy, res_valid}, 32'd2);
    tick();
    eng_rsp_valid = 1'b0;
    @(negedge clk);
    chk("lat c3 res_valid", 32'(res_valid), 32'd1);
    chk("lat c3 res_gcd", 32'(res_gcd), 32'd6);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk("lat c4 op_ready", 32'(op_ready), 32'd1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset in WAIT, then a late response in IDLE.
    tick();
    op_valid = 1'b1; op_a = 8'd40; op_b = 8'd30; eng_req_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    eng_req_ready = 1'b0;
    @(negedge clk);
    chk("rst pre busy", 32'(busy), 32'd1);
    tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk_reset_outputs("rst mid");
    tick();
    eng_rsp_valid = 1'b1; eng_rsp_gcd = 8'd3;
    tick();
    eng_rsp_valid = 1'b0;
    chk_reset_outputs("late rsp");
    begin
      vec_t v;
      v = '{8'd8, 8'd12, 8'd4, 0, 0, 1'b0, 8'd4, 1'b0};
      run_vec(v, 99);
    end

    // WAIT with no response.
    tick();
    op_valid = 1'b1; op_a = 8'd10; op_b = 8'd4; eng_req_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    eng_req_ready = 1'b0;
`ifdef GCD_REQ_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to waiting", {30'd0, busy, res_valid}, 32'd2);
      tick();
    end
    @(negedge clk);
    chk("to res_valid", 32'(res_valid), 32'd1);
    chk("to gcd err", {23'd0, res_gcd, res_err}, 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    // Response in the final WAIT cycle wins over the timeout.
    tick();
    op_valid = 1'b1; op_a = 8'd10; op_b = 8'd4; eng_req_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    eng_req_ready = 1'b0;
    repeat (3) tick();
    eng_rsp_valid = 1'b1; eng_rsp_gcd = 8'd2;
    tick();
    eng_rsp_valid = 1'b0;
    @(negedge clk);
    chk("to tie res_valid", 32'(res_valid), 32'd1);
    chk("to tie gcd err", {23'd0, res_gcd, res_err}, {23'd0, 8'd2, 1'b0});
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b1 || op_ready !== 1'b0 || i % 25 == 0)
        chk("no-timeout wait", {29'd0, busy, res_valid, op_ready}, 32'd4);
      tick();
    end
    eng_rsp_valid = 1'b1; eng_rsp_gcd = 8'd2;
    tick();
    eng_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late rsp res_valid", 32'(res_valid), 32'd1);
    chk("late rsp gcd err", {23'd0, res_gcd, res_err}, {23'd0, 8'd2, 1'b0});
`endif
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk("final idle", 32'(op_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
